// File: rtl/lcd_timing_gen_pkg.sv
// Shared timing constants for the 800x480 parallel-RGB panel.
// The display pixel path imports the same values so both sides agree on
// where the visible window sits inside the raw raster.
package lcd_timing_pkg;

  // Horizontal timing in pixel clocks
  localparam int LCD_H_SYNC   = 48;
  localparam int LCD_H_BACK   = 40;
  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_H_FRONT  = 40;
  localparam int LCD_H_TOTAL  = LCD_H_SYNC + LCD_H_BACK + LCD_H_ACTIVE + LCD_H_FRONT;

  // Vertical timing in lines
  localparam int LCD_V_SYNC   = 3;
  localparam int LCD_V_BACK   = 29;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_V_FRONT  = 13;
  localparam int LCD_V_TOTAL  = LCD_V_SYNC + LCD_V_BACK + LCD_V_ACTIVE + LCD_V_FRONT;

  // Visible window expressed in raw raster coordinates
  localparam int SCREEN_WIDTH   = LCD_H_ACTIVE;
  localparam int SCREEN_HEIGHT  = LCD_V_ACTIVE;
  localparam int SCREEN_START_X = LCD_H_SYNC + LCD_H_BACK;
  localparam int SCREEN_START_Y = LCD_V_SYNC + LCD_V_BACK;

  // Coordinate and timestamp widths
  localparam int LCD_X_BITS    = 11;
  localparam int LCD_Y_BITS    = 10;
  localparam int LCD_TIME_BITS = 32;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '0;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Scan-side bus between the timing generator (master) and the display
// pixel block (slave): coordinates and timing out, colour back.
interface lcd_timing_gen_if
  import lcd_timing_pkg::*;
#(
  parameter int X_BITS    = LCD_X_BITS,
  parameter int Y_BITS    = LCD_Y_BITS,
  parameter int TIME_BITS = LCD_TIME_BITS
);
  logic [X_BITS-1:0]    x;
  logic [Y_BITS-1:0]    y;
  logic                 valid;
  logic [TIME_BITS-1:0] cur_time;
  logic                 frame_start;
  logic [7:0]           r_in;
  logic [7:0]           g_in;
  logic [7:0]           b_in;

  modport master (
    output x, y, valid, cur_time, frame_start,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x, y, valid, cur_time, frame_start,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/lcd_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter with a terminal-count flag
// plus decode of the sync window and the active (visible) window.
module lcd_axis_counter #(
  parameter int BITS      = 11,
  parameter int TOTAL     = 928,
  parameter int SYNC      = 48,
  parameter int ACT_START = 88,
  parameter int ACT_END   = 888
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  output logic [BITS-1:0] o_count,
  output logic            o_tc,
  output logic            o_sync,
  output logic            o_active
);

  localparam logic [BITS-1:0] LAST      = BITS'(TOTAL - 1);
  localparam logic [BITS-1:0] STEP      = BITS'(1);
  localparam logic [BITS-1:0] SYNC_END  = BITS'(SYNC);
  localparam logic [BITS-1:0] ACT_FIRST = BITS'(ACT_START);
  localparam logic [BITS-1:0] ACT_LIMIT = BITS'(ACT_END);

  // A total that does not fit the counter would silently alias positions
  if (longint'(TOTAL) > (longint'(1) << BITS)) begin : g_range_check
    $error("lcd_axis_counter: TOTAL %0d does not fit in %0d bits", TOTAL, BITS);
  end

  logic [BITS-1:0] r_count;

  // Advance on enable, wrapping to zero after the last position of the axis
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + STEP;
    end
  end

  assign o_count  = r_count;
  assign o_tc     = (r_count == LAST);
  assign o_sync   = (r_count < SYNC_END);
  assign o_active = (r_count >= ACT_FIRST) && (r_count < ACT_LIMIT);

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: sweeps raw panel coordinates for the display
// pixel block and registers its colour together with hsync/vsync/de so
// every panel pin lags the coordinates by exactly one pixel step.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC          = LCD_H_SYNC,
  parameter int H_BACK          = LCD_H_BACK,
  parameter int H_ACTIVE        = LCD_H_ACTIVE,
  parameter int H_FRONT         = LCD_H_FRONT,
  parameter int V_SYNC          = LCD_V_SYNC,
  parameter int V_BACK          = LCD_V_BACK,
  parameter int V_ACTIVE        = LCD_V_ACTIVE,
  parameter int V_FRONT         = LCD_V_FRONT,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int X_BITS          = LCD_X_BITS,
  parameter int Y_BITS          = LCD_Y_BITS,
  parameter int TIME_BITS       = LCD_TIME_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pix_en,
  lcd_timing_gen_if.master pix_if,
  output logic [7:0]       o_lcd_r,
  output logic [7:0]       o_lcd_g,
  output logic [7:0]       o_lcd_b,
  output logic             o_lcd_hsync,
  output logic             o_lcd_vsync,
  output logic             o_lcd_de
);

  localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_START = H_SYNC + H_BACK;
  localparam int V_ACT_START = V_SYNC + V_BACK;

  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [TIME_BITS-1:0] TIME_ONE = TIME_BITS'(1);

  logic [X_BITS-1:0] w_h_count;
  logic [Y_BITS-1:0] w_v_count;
  logic w_step, w_v_en, w_wrap, w_de;
  logic w_h_tc, w_h_sync, w_h_active;
  logic w_v_tc, w_v_sync, w_v_active;
  rgb_t w_pixel;

  logic                 r_valid;
  logic [TIME_BITS-1:0] r_cur_time;
  logic                 r_frame_start;
  logic                 r_first_pending;
  rgb_t                 r_lcd_rgb;
  logic                 r_lcd_de;
  logic                 r_lcd_hsync;
  logic                 r_lcd_vsync;

  // The scan only moves once the generator is running, so the cycle after
  // reset always presents (0,0) before the first step
  assign w_step  = i_pix_en & r_valid;
  assign w_v_en  = w_step & w_h_tc;
  assign w_wrap  = w_step & w_h_tc & w_v_tc;
  assign w_de    = w_h_active & w_v_active;
  assign w_pixel = '{r: pix_if.r_in, g: pix_if.g_in, b: pix_if.b_in};

  lcd_axis_counter #(
    .BITS(X_BITS), .TOTAL(H_TOTAL), .SYNC(H_SYNC),
    .ACT_START(H_ACT_START), .ACT_END(H_ACT_START + H_ACTIVE)
  ) u_h_counter (
    .clk(clk), .rst(rst), .i_en(w_step),
    .o_count(w_h_count), .o_tc(w_h_tc), .o_sync(w_h_sync), .o_active(w_h_active)
  );

  lcd_axis_counter #(
    .BITS(Y_BITS), .TOTAL(V_TOTAL), .SYNC(V_SYNC),
    .ACT_START(V_ACT_START), .ACT_END(V_ACT_START + V_ACTIVE)
  ) u_v_counter (
    .clk(clk), .rst(rst), .i_en(w_v_en),
    .o_count(w_v_count), .o_tc(w_v_tc), .o_sync(w_v_sync), .o_active(w_v_active)
  );

  // Running flag and free-running timestamp, independent of the pixel enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_cur_time <= '0;
    end else begin
      r_valid    <= 1'b1;
      r_cur_time <= r_cur_time + TIME_ONE;
    end
  end

  // Frame start: once for the first enabled edge after reset, then on every wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start   <= 1'b0;
      r_first_pending <= 1'b1;
    end else begin
      r_frame_start <= i_pix_en & (r_first_pending | w_wrap);
      if (i_pix_en) begin
        r_first_pending <= 1'b0;
      end
    end
  end

  // Pin stage: capture the decode of the position being left, colour blanked
  // outside the visible window, all pins held while the scan is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcd_rgb   <= BLACK;
      r_lcd_de    <= 1'b0;
      r_lcd_hsync <= SYNC_OFF;
      r_lcd_vsync <= SYNC_OFF;
    end else if (w_step) begin
      r_lcd_rgb   <= w_de ? w_pixel : BLACK;
      r_lcd_de    <= w_de;
      r_lcd_hsync <= w_h_sync ? SYNC_ON : SYNC_OFF;
      r_lcd_vsync <= w_v_sync ? SYNC_ON : SYNC_OFF;
    end
  end

  assign pix_if.x           = w_h_count;
  assign pix_if.y           = w_v_count;
  assign pix_if.valid       = r_valid;
  assign pix_if.cur_time    = r_cur_time;
  assign pix_if.frame_start = r_frame_start;

  assign o_lcd_r     = r_lcd_rgb.r;
  assign o_lcd_g     = r_lcd_rgb.g;
  assign o_lcd_b     = r_lcd_rgb.b;
  assign o_lcd_de    = r_lcd_de;
  assign o_lcd_hsync = r_lcd_hsync;
  assign o_lcd_vsync = r_lcd_vsync;

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Raster timing generator for the 800x480 parallel-RGB LCD; the scan-side counterpart of the pixel display path.
- Sweeps raw panel coordinates, including the sync and porch regions, and drives x, y and valid into the display pixel block.
- Registers the RGB returned by that block and emits it with aligned hsync, vsync and de to the panel pins.
- Also provides a running time counter for the display's cur_time input and a per-frame start pulse.

Parameters:
- H_SYNC, 48: hsync width in pixel clocks.
- H_BACK, 40: horizontal back porch; H_SYNC+H_BACK = 88 = first active x.
- H_ACTIVE, 800: visible pixels per line.
- H_FRONT, 40: horizontal front porch; H_TOTAL = 928.
- V_SYNC, 3: vsync width in lines.
- V_BACK, 29: vertical back porch; V_SYNC+V_BACK = 32 = first active y.
- V_ACTIVE, 480: visible lines.
- V_FRONT, 13: vertical front porch; V_TOTAL = 525.
- SYNC_ACTIVE_LOW, 1: 1 means hsync/vsync are asserted low.
- X_BITS, 11: width of x.
- Y_BITS, 10: width of y.
- TIME_BITS, 32: width of cur_time.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-clock enable; all counters advance only when high.
- x  out  X_BITS  raw horizontal coordinate, 0..H_TOTAL-1.
- y  out  Y_BITS  raw vertical coordinate, 0..V_TOTAL-1.
- valid  out  1  generator running; qualifies x and y.
- cur_time  out  TIME_BITS  free-running count of clk cycles since reset.
- frame_start  out  1  one-cycle pulse when (x,y) becomes (0,0).
- r_in, g_in, b_in  in  8 each  pixel colour for the current (x,y), combinational from the display block.
- lcd_r, lcd_g, lcd_b  out  8 each  registered pixel data to the panel.
- lcd_hsync  out  1  registered hsync.
- lcd_vsync  out  1  registered vsync.
- lcd_de  out  1  registered data enable.

Behaviour:
- Reset (rst=1 at a clk edge) sets: x=0, y=0, valid=0, cur_time=0, frame_start=0, lcd_rgb=0, lcd_de=0, hsync/vsync at their deasserted level. Reset overrides pix_en.
- valid goes to 1 on the first clk edge with rst=0 and stays 1 until the next reset.
- cur_time increments every clk edge after reset, regardless of pix_en, and wraps modulo 2^TIME_BITS.
- Scan counter, on a clk edge with pix_en=1 and valid=1:
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At x=H_TOTAL-1 and y=V_TOTAL-1, both wrap to 0.
- With pix_en=0, x and y hold and all lcd_* outputs hold their values.
- frame_start is registered. It is 1 for exactly one clk cycle following the edge that loads (0,0) from the wrap. It is also 1 on the first pix_en edge after reset, which starts the first frame. It is 0 otherwise.
- Region decode on the current x and y:
  - hsync asserted for x < H_SYNC.
  - vsync asserted for y < V_SYNC.
  - de = (H_SYNC+H_BACK <= x < H_SYNC+H_BACK+H_ACTIVE) and (V_SYNC+V_BACK <= y < V_SYNC+V_BACK+V_ACTIVE).
  - Polarity is applied per SYNC_ACTIVE_LOW.
- Output stage, one register on a clk edge with pix_en=1:
  - lcd_r/g/b <= de ? {r_in,g_in,b_in} : 0.
  - lcd_de, lcd_hsync and lcd_vsync are registered from the same decode.
  - Pin outputs therefore lag x/y by exactly one pix_en step; all pins stay mutually aligned.
- Arithmetic:
  - Compares use X_BITS/Y_BITS unsigned values.
  - H_TOTAL must fit in X_BITS and V_TOTAL in Y_BITS; the implementation fails elaboration if they do not.
- Reset mid-frame: counters return to (0,0) next edge, pins are blanked immediately, and no partial-line artefacts are produced after reset.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - the timing constants (H_*/V_* defaults, totals, active start/end);
  - SCREEN_WIDTH=800, SCREEN_HEIGHT=480, SCREEN_START_X=88, SCREEN_START_Y=32, so the display path and this block share one source of truth;
  - the BLACK colour constant.
- One natural sub-module, lcd_axis_counter: a parameterised wrap counter with enable, terminal-count output and sync/active window decode. It is instantiated twice, horizontal and vertical; the vertical instance is enabled by the horizontal terminal count.

Test Plan:
- Reset release, pix_en=1:
  - valid=1 after 1 edge; x steps 0,1,2,...
  - lcd_hsync low for 48 pix_en steps, then high.
  - frame_start pulses once.
- x at 927, y at 10 -> next step x=0, y=11. x at 927, y at 524 -> next step (0,0), frame_start=1 for 1 cycle, lcd_vsync asserted low at the next step.
- Drive r_in=g_in=b_in=8'hFF constantly:
  - lcd_de=1 and lcd_rgb=FFFFFF exactly when the previous (x,y) was in [88,888)x[32,512).
  - lcd_de=0 and lcd_rgb=0 at x=87, 888 and y=31, 512.
  - Count of lcd_de high per frame = 384000.
- pix_en toggled 1,0,1,0:
  - x advances only on enabled edges, and pin outputs hold during gaps.
  - cur_time advances every clk.
  - Frame length = 928*525 enabled steps.
- Assert rst at (x=400, y=200) for 1 cycle:
  - next cycle x=0, y=0, valid=0, lcd_de=0, lcd_rgb=0, cur_time=0.
  - The scan restarts cleanly the cycle after.
- SYNC_ACTIVE_LOW=0 build: hsync/vsync high during sync windows (x<48, y<3); all other timing is identical.
